rs232rx_ctrl: RTL and testbench
===============================

RS232RX_CTRL -- requirements
Module: rs232rx_ctrl

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 133000000, integer clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, integer line rate in bit/s; CLOCK_FREQ/BAUD_RATE >= 4.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, receive FIFO entries; power of two, >= 2.
REQ-004 SHALL have port clock, input, 1 bit: rising-edge system clock.
REQ-005 SHALL have port resetn, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port rxd_pin, input, 1 bit: serial data, asynchronous to clock, idle high.
REQ-007 SHALL have port rtsn_pin, output, 1 bit: flow control, 0 = sender may transmit.
REQ-008 SHALL have port odata, output, 8 bits: FIFO head byte.
REQ-009 SHALL have port ovalid, output, 1 bit: odata holds a valid byte.
REQ-010 SHALL have port oready, input, 1 bit: consumer accepts odata this cycle.
REQ-011 SHALL have port frame_err, output, 1 bit: one-cycle pulse when a stop bit samples low.
REQ-012 SHALL have port overrun, output, 1 bit: one-cycle pulse when a good byte is dropped because the FIFO is full.

Function
REQ-013 SHALL pass rxd_pin through two flops (reset to 1) to form rxd; FSM sees only rxd (2-cycle latency).
REQ-014 SHALL use FULL = CLOCK_FREQ/BAUD_RATE and HALF = FULL/2 (integer division); the down-counter ticks when it reaches 0.
REQ-015 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-016 IDLE: rxd==0 -> START, counter loaded with HALF-1.
REQ-017 START tick: rxd==0 -> DATA, counter FULL-1, bit index 0; rxd==1 -> IDLE (glitch rejected, no pulse).
REQ-018 DATA tick: shift rxd in LSB-first, counter reload FULL-1; after the 8th bit -> STOP.
REQ-019 STOP tick: rxd==1 and FIFO not full -> push byte, go to IDLE.
REQ-020 STOP tick: rxd==1 and FIFO full -> overrun pulse, byte dropped, go to IDLE.
REQ-021 STOP tick: rxd==0 -> frame_err pulse, byte dropped, go to WAIT_HIGH.
REQ-022 WAIT_HIGH: rxd==1 -> IDLE; remains there for any length of break.
REQ-023 "Full" SHALL mean count==FIFO_DEPTH at the push cycle; a same-cycle pop does not prevent overrun.
REQ-024 ovalid SHALL equal (count!=0); odata SHALL be the head entry; a pop occurs when ovalid && oready.
REQ-025 A pushed byte SHALL appear on odata/ovalid the cycle after the push.
REQ-026 Simultaneous push and pop with count not full SHALL leave count unchanged and preserve order.
REQ-027 oready with ovalid==0 SHALL have no effect; pointers wrap modulo FIFO_DEPTH.
REQ-028 rtsn_pin SHALL be registered, equal to 1 when count >= FIFO_DEPTH-1, else 0.
REQ-029 odata and ovalid SHALL hold stable while ovalid && !oready.

Reset
REQ-030 On resetn low: FSM IDLE, counter 0, FIFO empty, sync flops 1, rtsn_pin 1, ovalid 0, odata 0, frame_err 0, overrun 0.
REQ-031 Reset mid-frame SHALL discard the partial byte; after release the FSM needs a fresh falling edge on rxd.
REQ-032 rtsn_pin SHALL go to 0 on the first clock edge after resetn release.

Verification (CLOCK_FREQ=16, BAUD_RATE=1: FULL=16, HALF=8; 16 clocks per bit)
REQ-033 Frame 0x55 with good stop bit, oready=1 -> one ovalid cycle with odata=0x55; frame_err=0, overrun=0.
REQ-034 Low pulse of 4 clocks on idle line -> FSM back to IDLE; no ovalid, no frame_err.
REQ-035 Frame 0xA3 with stop bit low, then 40 clocks low -> one frame_err pulse; nothing pushed; the next good frame 0x12 is received as 0x12.
REQ-036 oready=0, 4 frames 0x01..0x04 -> rtsn_pin=1 once count reaches 3; 5th frame 0x05 -> overrun pulse; oready=1 drains 0x01,0x02,0x03,0x04 in order.
REQ-037 Push coinciding with pop at count=2 -> count stays 2, order preserved.
REQ-038 resetn asserted during DATA bit 4 of a frame -> all outputs at reset values; the remainder of the frame produces no byte and no error pulse.

Source files
------------

// File: rtl/rs232rx_ctrl.sv
// RS-232 receiver: two-flop input synchronizer, mid-bit sampling FSM and a small
// receive FIFO with RTS flow control, frame-error and overrun pulses.
module rs232rx_ctrl #(
    parameter int CLOCK_FREQ = 133000000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       rxd_pin,
    output logic       rtsn_pin,
    output logic [7:0] odata,
    output logic       ovalid,
    input  logic       oready,
    output logic       frame_err,
    output logic       overrun
);
    localparam int FULL   = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF   = FULL / 2;
    localparam int CNT_W  = $clog2(FULL);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0]  FULL_M1 = CNT_W'(FULL - 1);
    localparam logic [CNT_W-1:0]  HALF_M1 = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [FCNT_W-1:0] DEPTH_C = FCNT_W'(FIFO_DEPTH);
    localparam logic [FCNT_W-1:0] RTS_LVL = FCNT_W'(FIFO_DEPTH - 1);
    localparam logic [FCNT_W-1:0] FCNT_ONE = FCNT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2:0]         bit_idx_q;
    logic [7:0]         shreg_q;
    logic               frame_err_q;
    logic               overrun_q;
    logic               rxd_meta_q;
    logic               rxd_q;
    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [FCNT_W-1:0]  fcount_q;
    logic [FCNT_W-1:0]  fcount_d;
    logic               rtsn_q;

    logic tick;
    logic fifo_full;
    logic push;
    logic pop;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rxd_meta_q <= 1'b1;
            rxd_q      <= 1'b1;
        end else begin
            rxd_meta_q <= rxd_pin;
            rxd_q      <= rxd_meta_q;
        end
    end

    assign tick      = (cnt_q == '0);
    assign fifo_full = (fcount_q == DEPTH_C);
    // A pop in the same cycle does not free a slot for this push.
    assign push      = (state_q == STOP) && tick && rxd_q && !fifo_full;
    assign pop       = (fcount_q != '0) && oready;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rxd_q) begin
                        state_q <= START;
                        cnt_q   <= HALF_M1;
                    end
                end
                START: begin
                    if (!tick) begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end else if (!rxd_q) begin
                        state_q   <= DATA;
                        cnt_q     <= FULL_M1;
                        bit_idx_q <= '0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                DATA: begin
                    if (!tick) begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end else begin
                        shreg_q   <= {rxd_q, shreg_q[7:1]};
                        cnt_q     <= FULL_M1;
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (!tick) begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end else if (rxd_q) begin
                        overrun_q <= fifo_full;
                        state_q   <= IDLE;
                    end else begin
                        frame_err_q <= 1'b1;
                        state_q     <= WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    if (rxd_q) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= shreg_q;
        end
    end

    always_comb begin
        fcount_d = fcount_q;
        case ({push, pop})
            2'b10:   fcount_d = fcount_q + FCNT_ONE;
            2'b01:   fcount_d = fcount_q - FCNT_ONE;
            default: fcount_d = fcount_q;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcount_q <= '0;
            rtsn_q   <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            fcount_q <= fcount_d;
            rtsn_q   <= (fcount_d >= RTS_LVL);
        end
    end

    // Head byte is forced to zero while empty so reset and idle read back as 0.
    assign ovalid    = (fcount_q != '0);
    assign odata     = ovalid ? mem_q[rd_ptr_q] : 8'h00;
    assign rtsn_pin  = rtsn_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_rs232rx_ctrl.sv
// Directed bench for rs232rx_ctrl at 16 clocks per bit: table of single frames
// plus hand sequences for glitch, overrun/flow control, push+pop and mid-frame reset.
module tb_rs232rx_ctrl;
    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       rxd_pin = 1'b1;
    logic       oready = 1'b1;
    logic       rtsn_pin;
    logic [7:0] odata;
    logic       ovalid;
    logic       frame_err;
    logic       overrun;

    rs232rx_ctrl #(.CLOCK_FREQ(16), .BAUD_RATE(1), .FIFO_DEPTH(4)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .rxd_pin   (rxd_pin),
        .rtsn_pin  (rtsn_pin),
        .odata     (odata),
        .ovalid    (ovalid),
        .oready    (oready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_bad = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    logic [7:0] rxq[$];

    // Accepted bytes and pulses are gathered on the falling edge.
    always @(negedge clock) begin
        if (resetn) begin
            if (ovalid && oready) rxq.push_back(odata);
            if (frame_err) ferr_cnt++;
            if (overrun) ovr_cnt++;
        end
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_n;
        logic [7:0] exp_byte;
        int         exp_ferr;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic drive_bit(input logic v, input int n);
        rxd_pin = v;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        drive_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) drive_bit(d[i], 16);
        if (stop) drive_bit(1'b1, 16);
        else      drive_bit(1'b0, 56);
        rxd_pin = 1'b1;
    endtask

    int bq, bf, bo;

    initial begin
        tbl[0] = '{8'h55, 1'b1, 1, 8'h55, 0};
        tbl[1] = '{8'hA3, 1'b0, 0, 8'h00, 1};
        tbl[2] = '{8'h12, 1'b1, 1, 8'h12, 0};
        tbl[3] = '{8'h00, 1'b1, 1, 8'h00, 0};
        tbl[4] = '{8'hFF, 1'b1, 1, 8'hFF, 0};
        tbl[5] = '{8'h80, 1'b1, 1, 8'h80, 0};
        tbl[6] = '{8'hC3, 1'b1, 1, 8'hC3, 0};

        // Reset values and release behaviour
        repeat (3) @(posedge clock);
        #1;
        check("rst_rtsn", 32'(rtsn_pin), 32'd1);
        check("rst_ovalid", 32'(ovalid), 32'd0);
        check("rst_odata", 32'(odata), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        resetn = 1'b1;
        check("rel_rtsn_before_edge", 32'(rtsn_pin), 32'd1);
        @(posedge clock);
        #1;
        check("rel_rtsn_after_edge", 32'(rtsn_pin), 32'd0);
        drive_bit(1'b1, 5);

        for (int v = 0; v < 7; v++) begin
            bq = rxq.size(); bf = ferr_cnt; bo = ovr_cnt;
            send_frame(tbl[v].data, tbl[v].stop);
            drive_bit(1'b1, 20);
            check($sformatf("vec%0d_nbytes", v), 32'(rxq.size() - bq), 32'(tbl[v].exp_n));
            if (tbl[v].exp_n == 1 && rxq.size() > bq)
                check($sformatf("vec%0d_byte", v), 32'(rxq[bq]), 32'(tbl[v].exp_byte));
            check($sformatf("vec%0d_ferr", v), 32'(ferr_cnt - bf), 32'(tbl[v].exp_ferr));
            check($sformatf("vec%0d_ovr", v), 32'(ovr_cnt - bo), 32'd0);
        end

        // Short low glitch is rejected, next frame still received
        bq = rxq.size(); bf = ferr_cnt;
        drive_bit(1'b0, 4);
        drive_bit(1'b1, 30);
        check("glitch_nbytes", 32'(rxq.size() - bq), 32'd0);
        check("glitch_ferr", 32'(ferr_cnt - bf), 32'd0);
        send_frame(8'h3C, 1'b1);
        drive_bit(1'b1, 20);
        check("glitch_next_n", 32'(rxq.size() - bq), 32'd1);
        if (rxq.size() > bq) check("glitch_next_byte", 32'(rxq[bq]), 32'h3C);

        // Fill FIFO with oready low, then overrun, then drain
        oready = 1'b0;
        bq = rxq.size(); bo = ovr_cnt;
        for (int k = 1; k <= 4; k++) begin
            send_frame(8'(k), 1'b1);
            drive_bit(1'b1, 10);
            if (k == 2) check("fill2_rtsn", 32'(rtsn_pin), 32'd0);
            if (k == 3) check("fill3_rtsn", 32'(rtsn_pin), 32'd1);
        end
        check("full_ovalid", 32'(ovalid), 32'd1);
        check("full_odata", 32'(odata), 32'h01);
        send_frame(8'h05, 1'b1);
        drive_bit(1'b1, 10);
        check("ovr_pulses", 32'(ovr_cnt - bo), 32'd1);
        check("ovr_odata_hold", 32'(odata), 32'h01);
        oready = 1'b1;
        drive_bit(1'b1, 10);
        check("drain_n", 32'(rxq.size() - bq), 32'd4);
        for (int k = 0; k < 4; k++)
            if (rxq.size() > bq + k) check($sformatf("drain_%0d", k), 32'(rxq[bq + k]), 32'(k + 1));
        check("drain_ovalid", 32'(ovalid), 32'd0);
        check("drain_rtsn", 32'(rtsn_pin), 32'd0);

        // Push coinciding with pop at count 2
        oready = 1'b0;
        send_frame(8'h21, 1'b1);
        drive_bit(1'b1, 10);
        send_frame(8'h22, 1'b1);
        drive_bit(1'b1, 10);
        bq = rxq.size();
        fork
            send_frame(8'h23, 1'b1);
            begin
                repeat (154) @(posedge clock);
                #1 oready = 1'b1;
                @(posedge clock);
                #1 oready = 1'b0;
                @(posedge clock);
                #1;
                check("pp_rtsn", 32'(rtsn_pin), 32'd0);
            end
        join
        drive_bit(1'b1, 10);
        check("pp_popped_n", 32'(rxq.size() - bq), 32'd1);
        if (rxq.size() > bq) check("pp_popped", 32'(rxq[bq]), 32'h21);
        check("pp_head", 32'(odata), 32'h22);
        check("pp_rtsn_after", 32'(rtsn_pin), 32'd0);
        oready = 1'b1;
        drive_bit(1'b1, 10);
        check("pp_drain_n", 32'(rxq.size() - bq), 32'd3);
        if (rxq.size() > bq + 2) begin
            check("pp_drain_1", 32'(rxq[bq + 1]), 32'h22);
            check("pp_drain_2", 32'(rxq[bq + 2]), 32'h23);
        end

        // Reset during data bit 4 of 0xF0
        bq = rxq.size(); bf = ferr_cnt;
        drive_bit(1'b0, 16);
        drive_bit(1'b0, 64);
        drive_bit(1'b1, 8);
        resetn = 1'b0;
        #1;
        check("mid_rst_rtsn", 32'(rtsn_pin), 32'd1);
        check("mid_rst_ovalid", 32'(ovalid), 32'd0);
        check("mid_rst_odata", 32'(odata), 32'd0);
        check("mid_rst_ferr", 32'(frame_err), 32'd0);
        check("mid_rst_ovr", 32'(overrun), 32'd0);
        drive_bit(1'b1, 4);
        resetn = 1'b1;
        drive_bit(1'b1, 100);
        check("mid_rst_nbytes", 32'(rxq.size() - bq), 32'd0);
        check("mid_rst_nferr", 32'(ferr_cnt - bf), 32'd0);
        check("mid_rst_rtsn_after", 32'(rtsn_pin), 32'd0);
        send_frame(8'h69, 1'b1);
        drive_bit(1'b1, 20);
        check("post_rst_n", 32'(rxq.size() - bq), 32'd1);
        if (rxq.size() > bq) check("post_rst_byte", 32'(rxq[bq]), 32'h69);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
